// File: rtl/block_sync_pkg.sv
// Shared definitions for the PCS block-lock path: state encoding, default
// window constants and the counter width derivation.
package block_sync_pkg;

  typedef enum logic [1:0] {
    ST_LOCK_INIT = 2'd0,
    ST_TEST_SH   = 2'd1,
    ST_SLIP_WAIT = 2'd2
  } lock_state_e;

  localparam int unsigned DEF_UNLOCKED_WINDOW = 64;
  localparam int unsigned DEF_LOCKED_WINDOW   = 1024;
  localparam int unsigned DEF_MAX_INVALID     = 65;
  localparam int unsigned DEF_SLIP_WAIT       = 2;

  // Counters must be able to hold the full locked window value.
  function automatic int unsigned win_width(input int unsigned locked_window);
    return $clog2(locked_window) + 1;
  endfunction

endpackage

// File: rtl/block_lock_if.sv
// Per-lane sync-header / block-lock signal bundle.
// Optional BLOCK_LOCK_STATS_EN adds the lock-loss statistics counter.
interface block_lock_if;
  logic i_signal_ok;
  logic i_valid;
  logic i_sh_valid;
  logic o_block_lock;
  logic o_slip;
  logic o_test_sh;
`ifdef BLOCK_LOCK_STATS_EN
  logic [15:0] o_lock_loss_cnt;

  modport master (
    output i_signal_ok, i_valid, i_sh_valid,
    input  o_block_lock, o_slip, o_test_sh, o_lock_loss_cnt
  );

  modport slave (
    input  i_signal_ok, i_valid, i_sh_valid,
    output o_block_lock, o_slip, o_test_sh, o_lock_loss_cnt
  );
`else
  modport master (
    output i_signal_ok, i_valid, i_sh_valid,
    input  o_block_lock, o_slip, o_test_sh
  );

  modport slave (
    input  i_signal_ok, i_valid, i_sh_valid,
    output o_block_lock, o_slip, o_test_sh
  );
`endif
endinterface

// File: rtl/sh_window_counter.sv
// Sync-header window counter pair (total headers and invalid headers) with
// terminal-count flags that report when the next increment hits a limit.
module sh_window_counter
  import block_sync_pkg::*;
#(
  parameter int unsigned UNLOCKED_WINDOW = DEF_UNLOCKED_WINDOW,
  parameter int unsigned LOCKED_WINDOW   = DEF_LOCKED_WINDOW,
  parameter int unsigned MAX_INVALID     = DEF_MAX_INVALID,
  parameter int unsigned NB_WIN          = win_width(LOCKED_WINDOW)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic clear_i,
  input  logic inc_i,
  input  logic inc_invalid_i,
  output logic sh_unlocked_tc_o,
  output logic sh_locked_tc_o,
  output logic invld_tc_o
);

  localparam logic [NB_WIN-1:0] UNL_LAST = NB_WIN'(UNLOCKED_WINDOW - 1);
  localparam logic [NB_WIN-1:0] LCK_LAST = NB_WIN'(LOCKED_WINDOW - 1);
  localparam logic [NB_WIN-1:0] INV_LAST = NB_WIN'(MAX_INVALID - 1);

  logic [NB_WIN-1:0] sh_cnt_q, sh_cnt_d;
  logic [NB_WIN-1:0] invld_cnt_q, invld_cnt_d;

  always_comb begin
    sh_cnt_d    = sh_cnt_q;
    invld_cnt_d = invld_cnt_q;
    if (clear_i) begin
      sh_cnt_d    = '0;
      invld_cnt_d = '0;
    end else begin
      if (inc_i)         sh_cnt_d    = sh_cnt_q + NB_WIN'(1);
      if (inc_invalid_i) invld_cnt_d = invld_cnt_q + NB_WIN'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sh_cnt_q    <= '0;
      invld_cnt_q <= '0;
    end else begin
      sh_cnt_q    <= sh_cnt_d;
      invld_cnt_q <= invld_cnt_d;
    end
  end

  // Flags look one header ahead so the FSM can act on the same edge.
  assign sh_unlocked_tc_o = (sh_cnt_q == UNL_LAST);
  assign sh_locked_tc_o   = (sh_cnt_q == LCK_LAST);
  assign invld_tc_o       = (invld_cnt_q == INV_LAST);

endmodule

// File: rtl/block_lock_fsm.sv
// 100GbE PCS per-lane block-lock controller: header window testing, lock
// decision and bit-slip sequencing. Optional macro: BLOCK_LOCK_STATS_EN.
module block_lock_fsm
  import block_sync_pkg::*;
#(
  parameter int unsigned UNLOCKED_WINDOW = DEF_UNLOCKED_WINDOW,
  parameter int unsigned LOCKED_WINDOW   = DEF_LOCKED_WINDOW,
  parameter int unsigned MAX_INVALID     = DEF_MAX_INVALID,
  parameter int unsigned SLIP_WAIT       = DEF_SLIP_WAIT,
  parameter int unsigned NB_WIN          = win_width(LOCKED_WINDOW)
) (
  input  logic        i_clock,
  input  logic        i_reset,
  block_lock_if.slave bus
);

  localparam int unsigned WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  lock_state_e       state_q, state_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic cnt_clear, cnt_inc, cnt_inc_invalid;
  logic sh_unlocked_tc, sh_locked_tc, invld_tc;

  sh_window_counter #(
    .UNLOCKED_WINDOW (UNLOCKED_WINDOW),
    .LOCKED_WINDOW   (LOCKED_WINDOW),
    .MAX_INVALID     (MAX_INVALID),
    .NB_WIN          (NB_WIN)
  ) u_win_cnt (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .clear_i          (cnt_clear),
    .inc_i            (cnt_inc),
    .inc_invalid_i    (cnt_inc_invalid),
    .sh_unlocked_tc_o (sh_unlocked_tc),
    .sh_locked_tc_o   (sh_locked_tc),
    .invld_tc_o       (invld_tc)
  );

  always_comb begin
    state_d         = state_q;
    lock_d          = lock_q;
    slip_d          = 1'b0;
    wait_d          = wait_q;
    cnt_clear       = 1'b0;
    cnt_inc         = 1'b0;
    cnt_inc_invalid = 1'b0;

    // Loss of PMA signal overrides everything, including a slip about to fire.
    if (!bus.i_signal_ok) begin
      state_d   = ST_LOCK_INIT;
      lock_d    = 1'b0;
      wait_d    = '0;
      cnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_LOCK_INIT: begin
          lock_d    = 1'b0;
          cnt_clear = 1'b1;
          state_d   = ST_TEST_SH;
        end

        ST_TEST_SH: begin
          if (bus.i_valid) begin
            if (!lock_q) begin
              if (!bus.i_sh_valid) begin
                slip_d    = 1'b1;
                cnt_clear = 1'b1;
                wait_d    = '0;
                state_d   = ST_SLIP_WAIT;
              end else if (sh_unlocked_tc) begin
                lock_d    = 1'b1;
                cnt_clear = 1'b1;
              end else begin
                cnt_inc = 1'b1;
              end
            end else begin
              // Invalid limit is checked first so it wins at the window end.
              if (!bus.i_sh_valid && invld_tc) begin
                lock_d    = 1'b0;
                slip_d    = 1'b1;
                cnt_clear = 1'b1;
                wait_d    = '0;
                state_d   = ST_SLIP_WAIT;
              end else if (sh_locked_tc) begin
                cnt_clear = 1'b1;
              end else begin
                cnt_inc         = 1'b1;
                cnt_inc_invalid = ~bus.i_sh_valid;
              end
            end
          end
        end

        ST_SLIP_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            wait_d    = '0;
            cnt_clear = 1'b1;
            state_d   = ST_TEST_SH;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end

        default: begin
          state_d   = ST_LOCK_INIT;
          lock_d    = 1'b0;
          wait_d    = '0;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_LOCK_INIT;
      lock_q  <= 1'b0;
      slip_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      slip_q  <= slip_d;
      wait_q  <= wait_d;
    end
  end

  assign bus.o_block_lock = lock_q;
  assign bus.o_slip       = slip_q;
  assign bus.o_test_sh    = (state_q == ST_TEST_SH);

`ifdef BLOCK_LOCK_STATS_EN
  // A lock drop that also slips can only come from the invalid-header limit.
  logic        loss_evt;
  logic [15:0] loss_cnt_q, loss_cnt_d;

  assign loss_evt = lock_q & ~lock_d & slip_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_evt && (loss_cnt_q != 16'hFFFF)) loss_cnt_d = loss_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) loss_cnt_q <= '0;
    else         loss_cnt_q <= loss_cnt_d;
  end

  assign bus.o_lock_loss_cnt = loss_cnt_q;
`endif

endmodule
